alu_serial_sequencer: RTL and testbench

- Sequences a single one-bit ALU slice over WIDTH clock cycles to produce a full-width ALU result, LSB first.
- Used where area matters more than latency, e.g. the multi-cycle datapath's auxiliary ALU.
- Decodes the 4-bit ALU control code into slice controls (ainvert, binvert, operation, carryin, less).
- Chains the carry through a flop and assembles result, zero and overflow.

---
 rtl/alu_serial_sequencer.sv | 150 +++++++++++++++
 tb/tb_alu_serial_sequencer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: drives a one-bit ALU slice for WIDTH cycles, LSB first,
// and assembles result, zero and overflow from the slice's outputs.
module alu_serial_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             slice_a,
   output logic             slice_b,
   output logic             slice_ainvert,
   output logic             slice_binvert,
   output logic             slice_carryin,
   output logic             slice_less,
   output logic [1:0]       slice_operation,
   input  logic             slice_result,
   input  logic             slice_carryout,
   input  logic             slice_set,
   input  logic             slice_overflow
);
   localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   typedef enum logic [2:0] {OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR, OP_INV} opc_t;

   state_t           r_state, w_nxt;
   opc_t             r_opc, w_dec_opc;
   logic [WIDTH-1:0] r_a, r_b, r_shift, w_asm, w_fin_res;
   logic [IW-1:0]    r_idx;
   logic             r_carry, w_fin_ovf, w_run, w_last, w_dec_binv;
   logic             w_ainv, w_binv;
   logic [1:0]       w_op;

   always_comb begin
      unique case (alu_ctrl)
         4'b0000: w_dec_opc = OP_AND;
         4'b0001: w_dec_opc = OP_OR;
         4'b0010: w_dec_opc = OP_ADD;
         4'b0110: w_dec_opc = OP_SUB;
         4'b0111: w_dec_opc = OP_SLT;
         4'b1100: w_dec_opc = OP_NOR;
         default: w_dec_opc = OP_INV;
      endcase
   end

   assign w_dec_binv = (w_dec_opc == OP_SUB) || (w_dec_opc == OP_SLT) || (w_dec_opc == OP_NOR);

   always_comb begin
      w_ainv = 1'b0;
      w_binv = 1'b0;
      w_op   = 2'b00;
      case (r_opc)
         OP_OR:   w_op = 2'b01;
         OP_ADD:  w_op = 2'b10;
         OP_SUB,
         OP_SLT:  begin w_binv = 1'b1; w_op = 2'b10; end
         OP_NOR:  begin w_ainv = 1'b1; w_binv = 1'b1; end
         default: ;
      endcase
   end

   assign w_run  = (r_state == S_RUN);
   assign w_last = (r_idx == LAST);
   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);

   assign slice_a         = w_run & r_a[r_idx];
   assign slice_b         = w_run & r_b[r_idx];
   assign slice_ainvert   = w_run & w_ainv;
   assign slice_binvert   = w_run & w_binv;
   assign slice_carryin   = w_run & r_carry;
   assign slice_less      = 1'b0;
   assign slice_operation = w_run ? w_op : 2'b00;

   // The MSB arrives from the slice on the same edge that finishes the operation
   assign w_asm = {slice_result, r_shift[WIDTH-2:0]};

   always_comb begin
      w_fin_res = '0;
      w_fin_ovf = 1'b0;
      case (r_opc)
         OP_ADD, OP_SUB:        begin w_fin_res = w_asm; w_fin_ovf = slice_overflow; end
         OP_SLT:                w_fin_res = {{(WIDTH-1){1'b0}}, slice_set ^ slice_overflow};
         OP_AND, OP_OR, OP_NOR: w_fin_res = w_asm;
         default: ;
      endcase
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_nxt = S_RUN;
         S_RUN:   if (w_last) w_nxt = S_DONE;
         S_DONE:  w_nxt = S_IDLE;
         default: w_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_a      <= '0;
         r_b      <= '0;
         r_shift  <= '0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_opc    <= OP_AND;
         result   <= '0;
         zero     <= 1'b1;
         overflow <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (start) begin
               r_a     <= a;
               r_b     <= b;
               r_opc   <= w_dec_opc;
               r_idx   <= '0;
               r_carry <= w_dec_binv;
               r_shift <= '0;
            end
            S_RUN: begin
               r_shift[r_idx] <= slice_result;
               r_carry        <= slice_carryout;
               if (w_last) begin
                  r_idx    <= '0;
                  result   <= w_fin_res;
                  zero     <= (w_fin_res == '0);
                  overflow <= w_fin_ovf;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Directed bench for alu_serial_sequencer with a behavioural one-bit ALU slice attached.
module tb_alu_serial_sequencer;
   localparam int W = 32;

   logic         clk = 1'b0, reset, start;
   logic [3:0]   alu_ctrl;
   logic [W-1:0] a, b, result;
   logic         busy, done, zero, overflow;
   logic         slice_a, slice_b, slice_ainvert, slice_binvert, slice_carryin, slice_less;
   logic [1:0]   slice_operation;
   logic         slice_result, slice_carryout, slice_set, slice_overflow;
   logic         sa, sb, sum;
   int           n_chk = 0, n_err = 0;

   always #5 clk = ~clk;

   alu_serial_sequencer #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .alu_ctrl(alu_ctrl), .a(a), .b(b),
      .busy(busy), .done(done), .result(result), .zero(zero), .overflow(overflow),
      .slice_a(slice_a), .slice_b(slice_b), .slice_ainvert(slice_ainvert),
      .slice_binvert(slice_binvert), .slice_carryin(slice_carryin), .slice_less(slice_less),
      .slice_operation(slice_operation), .slice_result(slice_result),
      .slice_carryout(slice_carryout), .slice_set(slice_set), .slice_overflow(slice_overflow)
   );

   // Reference one-bit ALU slice
   assign sa             = slice_a ^ slice_ainvert;
   assign sb             = slice_b ^ slice_binvert;
   assign sum            = sa ^ sb ^ slice_carryin;
   assign slice_carryout = (sa & sb) | (sa & slice_carryin) | (sb & slice_carryin);
   assign slice_set      = sum;
   assign slice_overflow = slice_carryin ^ slice_carryout;
   always_comb begin
      case (slice_operation)
         2'b00:   slice_result = sa & sb;
         2'b01:   slice_result = sa | sb;
         2'b10:   slice_result = sum;
         default: slice_result = slice_less;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Run one operation; optionally pulse start mid-run and scramble operands after accept
   task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic [W-1:0] er, input logic eo,
                         input bit pulse_mid);
      int n;
      @(negedge clk);
      alu_ctrl = c; a = va; b = vb; start = 1'b1;
      n = 1;
      while (1) begin
         @(negedge clk);
         n++;
         if (n == 2) begin start = 1'b0; a = ~va; b = ~vb; alu_ctrl = 4'b0010; end
         if (pulse_mid && n == 10) start = 1'b1;
         if (pulse_mid && n == 11) start = 1'b0;
         if (done || n > 100) break;
      end
      chk({tag, " latency"}, n, W + 2);
      chk({tag, " result"}, result, er);
      chk({tag, " zero"}, zero, (er == '0));
      chk({tag, " ovf"}, overflow, eo);
      chk({tag, " busy_in_done"}, busy, 1'b1);
      @(negedge clk);
      chk({tag, " done_pulse"}, {busy, done}, 2'b00);
   endtask

   initial begin
      int n, d1, d2, nd;
      reset = 1'b1; start = 1'b0; alu_ctrl = 4'b0; a = '0; b = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst busy_done_ovf_zero", {busy, done, overflow, zero}, 4'b0001);
      chk("rst result", result, 32'h0);
      chk("rst slices", {slice_a, slice_b, slice_ainvert, slice_binvert, slice_carryin,
                         slice_less, slice_operation}, 8'h00);

      run_op("add_ovf", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 0);
      run_op("add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 0);
      run_op("sub_eq", 4'b0110, 32'd5, 32'd5, 32'h0, 1'b0, 0);
      run_op("sub_ovf", 4'b0110, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b1, 0);
      run_op("slt_neg", 4'b0111, 32'h80000000, 32'h1, 32'h1, 1'b0, 0);
      run_op("slt_ovfcorr", 4'b0111, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 0);
      run_op("and", 4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 0);
      run_op("or", 4'b0001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 0);
      run_op("nor", 4'b1100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1);
      run_op("invalid", 4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 0);

      // start held high: accepts only in IDLE after each done
      @(negedge clk);
      alu_ctrl = 4'b0010; a = 32'd3; b = 32'd4; start = 1'b1;
      d1 = 0; d2 = 0; nd = 0;
      for (n = 2; n <= 70; n++) begin
         @(negedge clk);
         if (done) begin
            nd++;
            if (nd == 1) d1 = n; else d2 = n;
         end
      end
      start = 1'b0;
      chk("b2b done_count", nd, 2);
      chk("b2b first_done", d1, W + 2);
      chk("b2b second_done", d2, 2 * (W + 2));
      chk("b2b third_accept", busy, 1'b1);
      n = 0;
      while (busy && n < 100) begin @(negedge clk); n++; end
      chk("b2b drain", busy, 1'b0);
      chk("b2b result", result, 32'd7);

      run_op("pre_rst", 4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b1, 0);

      // reset during RUN at bit 10
      @(negedge clk);
      alu_ctrl = 4'b0010; a = 32'h12345678; b = 32'h11111111; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid slice_op", slice_operation, 2'b10);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("mid_rst busy_done_zero_ovf", {busy, done, zero, overflow}, 4'b0010);
      chk("mid_rst result", result, 32'h0);
      nd = 0;
      repeat (40) begin @(negedge clk); if (done || busy) nd++; end
      chk("mid_rst no_done", nd, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
